decim2_filter: RTL and testbench

- Streaming 2:1 horizontal decimator; the downsampling counterpart of the 4-tap half-pel interpolator.
- Uses the same symmetric kernel (-12, 76, 76, -12; sum 128), with clamp-to-edge padding at both ends of each line.
- Consumes one 8-bit luma sample per accepted beat and emits one filtered sample per two inputs.
- Sits between the line buffer reader and the downscaled-frame writer.

---
 rtl/decim2_pkg.sv | 18 +
 rtl/decim2_mac.sv | 45 ++++
 rtl/decim2_filter.sv | 138 +++++++++++++
 tb/tb_decim2_filter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decim2_pkg.sv
// Shared constants and types for the 2:1 horizontal decimator.
// Optional clip counter is enabled with DECIM2_CLIPCNT_EN (see decim2_filter).
package decim2_pkg;

  localparam int C0    = -12;
  localparam int C1    = 76;
  localparam int C2    = 76;
  localparam int C3    = -12;
  localparam int SHIFT = 7;
  localparam int ROUND = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } decim2_state_e;

endpackage

// File: rtl/decim2_mac.sv
// Combinational 4-tap symmetric MAC with rounding, arithmetic shift and clip
// to the unsigned sample range; clipped flags either saturation direction.
module decim2_mac
  import decim2_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] y,
  output logic              clipped
);

  localparam int ACC_W = DATA_W + 10;
  localparam logic signed [ACC_W-1:0] K0   = ACC_W'(C0);
  localparam logic signed [ACC_W-1:0] K1   = ACC_W'(C1);
  localparam logic signed [ACC_W-1:0] K2   = ACC_W'(C2);
  localparam logic signed [ACC_W-1:0] K3   = ACC_W'(C3);
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(ROUND);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << DATA_W) - 1);

  function automatic logic signed [ACC_W-1:0] ext(input logic [DATA_W-1:0] v);
    return signed'({{(ACC_W-DATA_W){1'b0}}, v});
  endfunction

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] rnd;

  always_comb begin
    acc     = K0 * ext(a) + K1 * ext(b) + K2 * ext(c) + K3 * ext(d);
    rnd     = (acc + RND) >>> SHIFT;
    y       = rnd[DATA_W-1:0];
    clipped = 1'b0;
    if (rnd[ACC_W-1]) begin
      y       = '0;
      clipped = 1'b1;
    end else if (rnd > MAXV) begin
      y       = '1;
      clipped = 1'b1;
    end
  end

endmodule

// File: rtl/decim2_filter.sv
// Streaming 2:1 horizontal decimator, clamp-to-edge at both line ends.
// Define DECIM2_CLIPCNT_EN to add the saturating clip_count output.
module decim2_filter
  import decim2_pkg::*;
#(
  parameter int DATA_W = 8
`ifdef DECIM2_CLIPCNT_EN
  , parameter int CLIPCNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
`ifdef DECIM2_CLIPCNT_EN
  output logic [CLIPCNT_W-1:0] clip_count,
`endif
  output decim2_state_e        state
);

  // Handshake: a beat transfers on a rising edge where valid && ready; the
  // output register holds out_data/out_last while out_valid && !out_ready.

  decim2_state_e     state_d;
  logic [DATA_W-1:0] w0, w1, w2;
  logic              odd_next;
  logic              adv, accept, emit;
  logic [DATA_W-1:0] mac_c, mac_d, mac_y;
  logic              mac_clip;

  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = (state != FLUSH) && adv;
    accept   = in_valid && in_ready;
    state_d  = state;
    emit     = 1'b0;
    mac_c    = w2;
    mac_d    = in_data;
    case (state)
      IDLE: if (accept) state_d = in_last ? FLUSH : RUN;
      RUN: begin
        if (accept) begin
          emit = !odd_next;
          if (in_last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Odd-length line ends on an even sample (w1); even-length on w2.
        mac_c = odd_next ? w1 : w2;
        mac_d = odd_next ? w1 : w2;
        if (adv) begin
          emit    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  decim2_mac #(.DATA_W(DATA_W)) u_mac (
    .a       (w0),
    .b       (w1),
    .c       (mac_c),
    .d       (mac_d),
    .y       (mac_y),
    .clipped (mac_clip)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w0       <= '0;
      w1       <= '0;
      w2       <= '0;
      odd_next <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        w0       <= in_data;
        w1       <= in_data;
        odd_next <= 1'b1;
      end else begin
        if (odd_next) begin
          w2 <= in_data;
        end else begin
          w0 <= w2;
          w1 <= in_data;
        end
        odd_next <= !odd_next;
      end
    end
  end

`ifdef DECIM2_CLIPCNT_EN
  logic out_clip;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
`ifdef DECIM2_CLIPCNT_EN
      out_clip  <= 1'b0;
`endif
    end else if (emit) begin
      out_valid <= 1'b1;
      out_last  <= (state == FLUSH);
      out_data  <= mac_y;
`ifdef DECIM2_CLIPCNT_EN
      out_clip  <= mac_clip;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECIM2_CLIPCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) clip_count <= '0;
    else if (out_valid && out_ready && out_clip && (clip_count != '1))
      clip_count <= clip_count + 1'b1;
  end
`else
  logic unused_clip;
  assign unused_clip = mac_clip;
`endif

endmodule

// File: tb/tb_decim2_filter.sv
// Self-checking bench for decim2_filter: reference model feeds an expected
// queue, a negedge monitor pops and compares every output transfer.
module tb_decim2_filter;
  import decim2_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;
  decim2_state_e dbg_state;
`ifdef DECIM2_CLIPCNT_EN
  logic [15:0]  clip_count;
`endif

  always #5 clk = ~clk;

  decim2_filter #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
`ifdef DECIM2_CLIPCNT_EN
    .clip_count (clip_count),
`endif
    .state      (dbg_state)
  );

  int           vectors = 0;
  int           miscompares = 0;
  logic [W:0]   exp_q[$];
  logic [W-1:0] line_q[$];
  int           exp_clips = 0;
  bit           rand_ready = 1'b0;
  bit           count_low = 1'b0;
  int           low_ready_cnt = 0;
  bit           hold_pend = 1'b0;
  logic [W:0]   hold_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampi(input int i, input int n);
    if (i < 0) return 0;
    if (i > n - 1) return n - 1;
    return i;
  endfunction

  function automatic int fref(input int a, input int b, input int c, input int d, output bit clip);
    int acc, y;
    acc  = -12 * a + 76 * b + 76 * c - 12 * d;
    y    = (acc + 64) >>> 7;
    clip = (y < 0) || (y > 255);
    if (y < 0) y = 0;
    if (y > 255) y = 255;
    return y;
  endfunction

  task automatic queue_line();
    int n, nout, y;
    bit clip;
    n    = line_q.size();
    nout = (n + 1) / 2;
    for (int k = 0; k < nout; k++) begin
      y = fref(int'(line_q[clampi(2*k-1, n)]), int'(line_q[clampi(2*k, n)]),
               int'(line_q[clampi(2*k+1, n)]), int'(line_q[clampi(2*k+2, n)]), clip);
      exp_q.push_back({(k == nout - 1), y[W-1:0]});
      if (clip) exp_clips++;
    end
  endtask

  task automatic drive_sample(input logic [W-1:0] d, input logic last);
    int cnt = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      cnt++;
      if (cnt > 200) begin
        check("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_line();
    queue_line();
    for (int i = 0; i < line_q.size(); i++)
      drive_sample(line_q[i], i == line_q.size() - 1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check(tag, exp_q.size(), 0);
`ifdef DECIM2_CLIPCNT_EN
    check({tag, "_clipcnt"}, clip_count, exp_clips);
`endif
  endtask

  // Monitor: compare output transfers and stall-hold behaviour.
  always @(negedge clk) begin
    logic [W:0] e;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (count_low && !in_ready) low_ready_cnt++;
      if (hold_pend) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {out_last, out_data}, hold_val);
      end
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out", {out_last, out_data}, e);
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = {out_last, out_data};
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_state", dbg_state, IDLE);
`ifdef DECIM2_CLIPCNT_EN
    check("rst_clipcnt", clip_count, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 1);

    line_q = '{8'd10, 8'd20, 8'd30, 8'd40};
    send_line();
    wait_drain("line_ramp");

    line_q = '{8'd0, 8'd0, 8'd255, 8'd255};
    send_line();
    wait_drain("line_clip");

    line_q = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    low_ready_cnt = 0;
    count_low = 1'b1;
    send_line();
    repeat (3) @(posedge clk);
    #1;
    count_low = 1'b0;
    check("flush_gap", low_ready_cnt, 1);
    wait_drain("line_const");

    line_q = '{8'd77};
    send_line();
    line_q = '{8'd10, 8'd20, 8'd30};
    send_line();
    wait_drain("line_short");

    line_q.delete();
    for (int i = 0; i < 10; i++) line_q.push_back(8'($urandom_range(0, 255)));
    fork
      send_line();
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain("line_stall");

    out_ready = 1'b0;
    drive_sample(8'd5, 1'b0);
    drive_sample(8'd200, 1'b0);
    drive_sample(8'd9, 1'b0);
    check("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_last", out_last, 0);
    check("async_rst_state", dbg_state, IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    exp_clips = 0;
    line_q = '{8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    send_line();
    wait_drain("line_after_rst");

    rand_ready = 1'b1;
    for (int l = 0; l < 6; l++) begin
      int n = $urandom_range(1, 9);
      line_q.delete();
      for (int i = 0; i < n; i++) line_q.push_back(8'($urandom_range(0, 255)));
      send_line();
    end
    wait_drain("line_random");
    rand_ready = 1'b0;
    #2 out_ready = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
